keypad_scan: RTL
================

Name: keypad_scan

Overview:
- Input-side counterpart to the multiplexed 7-segment display driver: scans a 4x4 hex keypad matrix, debounces it, and emits one code per press.
- Drives one active-low row at a time and reads active-low columns (board pull-ups).
- Accepted keys also shift into a 32-bit entry register. That register feeds the ALU operand/op inputs in place of raw switches.

Parameters:
- SCAN_DIV, 50000, clock cycles each row is driven (>=4).
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to change press state (>=1, <=15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- col  input  4  keypad columns, active-low, asynchronous to clk
- clr  input  1  synchronous clear of entry register
- row  output  4  keypad row drive, active-low, exactly one bit low
- key_code  output  4  code of last accepted key
- key_valid  output  1  one-cycle pulse per accepted press
- key_down  output  1  debounced "key held" level
- data  output  32  nibble-shift entry register

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: row=4'b1110, key_code=0, key_valid=0, key_down=0, data=0. Row index, divider, candidate, debounce count and FSM all cleared. Reset mid-scan or mid-press restarts at row 0 with no pulse.
- col passes through a 2-flop synchronizer before any use.
- Scanning:
  - Divider counts 0..SCAN_DIV-1. Row index r advances on wrap, 3 wraps to 0.
  - row = ~(4'b0001 << r).
  - Synchronized col is sampled on the divider's last cycle of each row period.
- Scan result, evaluated at end of row 3:
  - NONE: no low column bits seen.
  - SINGLE(code): exactly one low bit in exactly one row; code = {r[1:0], c[1:0]}, where c is the column index of the low bit.
  - MULTI: anything else.
- Debounce:
  - If the result equals the stored candidate, the count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise candidate = result and count = 1.
- FSM RELEASED:
  - Candidate is SINGLE with count reaching DEBOUNCE_SCANS -> go to PRESSED.
  - Same cycle: key_code = candidate code, key_valid = 1 for one cycle, key_down = 1, data = {data[27:0], code}.
  - MULTI never triggers acceptance.
- FSM PRESSED:
  - Candidate NONE with count reaching DEBOUNCE_SCANS -> go to RELEASED, key_down = 0.
  - SINGLE and MULTI results keep PRESSED. Rolling to a second key without release produces no new pulse.
- clr=1 sets data=0.
  - If clr and key acceptance coincide, data = {28'b0, code}.
  - clr does not affect the FSM, key_code or key_valid.
- Latency: acceptance occurs at the end of the DEBOUNCE_SCANS-th consistent full scan. Worst case is (DEBOUNCE_SCANS+1)*4*SCAN_DIV+2 cycles after a stable press.
- At most one key_valid per 4*SCAN_DIV cycles.

Test Plan:
1. Settings: SCAN_DIV=4, DEBOUNCE_SCANS=2. Bench matrix model pulls col[c] low when row[r] is low. Hold key r=2,c=1 stable -> exactly one key_valid pulse within 48+2 cycles, key_code=4'h9, key_down=1, data=32'h9. Release -> key_down=0 within 50 cycles, no extra pulse.
2. Enter keys 1,2,3,4,5,6,7,8,9 with release between each -> nine pulses, final data=32'h23456789 (oldest nibble shifted out).
3. Bounce: toggle key 0x5 every 3 cycles for 40 cycles, then hold stable -> no pulse during bounce, exactly one pulse with key_code=5 after stable.
4. Hold keys 0x0 and 0xF simultaneously from RELEASED -> no key_valid, key_down stays 0. Release 0xF, keep 0x0 -> one pulse, key_code=0.
5. Holding key 0x3, assert rst for 1 cycle mid-scan -> all outputs return to reset values next cycle. Key still held -> one fresh pulse after debounce.
6. data=32'h12, assert clr on the same cycle as acceptance of key 0xA -> data=32'h0000000A. clr alone -> data=0, key_code unchanged.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: row strobing, full-scan debounce and press FSM,
// emitting one code per press and shifting accepted nibbles into a 32-bit entry register.
`timescale 1ns/1ps
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    input  logic        clr,
    output logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [31:0] data
);
    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DB_MAX   = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;
    typedef enum logic {RELEASED, PRESSED} state_t;

    logic [3:0]       col_p0, col_p1;
    logic [DIV_W-1:0] div;
    logic [1:0]       r;
    res_t             acc_cls, cand_cls, nxt_cls;
    logic [3:0]       acc_code, cand_code, nxt_code;
    logic [3:0]       dbc, new_cnt;
    state_t           state;

    logic [3:0] low_cols;
    logic       one_low, last_cyc, scan_end, same, accept, release_ok;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= DB_MAX) ? DB_MAX : c + 4'd1;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (v[i]) idx = 2'(i);
        return idx;
    endfunction

    assign row      = ~(4'b0001 << r);
    assign low_cols = ~col_p1;
    assign one_low  = (low_cols != 4'd0) && ((low_cols & (low_cols - 4'd1)) == 4'd0);
    assign last_cyc = (div == DIV_LAST);
    assign scan_end = last_cyc && (r == 2'd3);

    // Fold the current row's sample into the running scan result; NONE/MULTI carry code 0
    // so candidate comparison only distinguishes codes for SINGLE.
    always_comb begin
        nxt_cls  = acc_cls;
        nxt_code = acc_code;
        if (low_cols != 4'd0) begin
            if (one_low && acc_cls == RES_NONE) begin
                nxt_cls  = RES_SINGLE;
                nxt_code = {r, low_index(low_cols)};
            end else begin
                nxt_cls  = RES_MULTI;
                nxt_code = 4'd0;
            end
        end
    end

    assign same       = (nxt_cls == cand_cls) && (nxt_code == cand_code);
    assign new_cnt    = same ? sat_inc(dbc) : 4'd1;
    assign accept     = scan_end && (state == RELEASED) && (nxt_cls == RES_SINGLE) && (new_cnt == DB_MAX);
    assign release_ok = scan_end && (state == PRESSED) && (nxt_cls == RES_NONE) && (new_cnt == DB_MAX);

    // Stage p0/p1: two-flop synchronizer for the asynchronous column inputs
    always_ff @(posedge clk) begin
        col_p0 <= col;
        col_p1 <= col_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            r         <= 2'd0;
            acc_cls   <= RES_NONE;
            acc_code  <= 4'd0;
            cand_cls  <= RES_NONE;
            cand_code <= 4'd0;
            dbc       <= 4'd0;
            state     <= RELEASED;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            data      <= 32'd0;
        end else begin
            key_valid <= 1'b0;
            if (last_cyc) begin
                div <= '0;
                r   <= r + 2'd1;
            end else begin
                div <= div + DIV_W'(1);
            end

            if (scan_end) begin
                acc_cls   <= RES_NONE;
                acc_code  <= 4'd0;
                cand_cls  <= nxt_cls;
                cand_code <= nxt_code;
                dbc       <= new_cnt;
            end else if (last_cyc) begin
                acc_cls  <= nxt_cls;
                acc_code <= nxt_code;
            end

            if (accept) begin
                state     <= PRESSED;
                key_code  <= nxt_code;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
            end else if (release_ok) begin
                state    <= RELEASED;
                key_down <= 1'b0;
            end

            if (clr)
                data <= accept ? {28'd0, nxt_code} : 32'd0;
            else if (accept)
                data <= {data[27:0], nxt_code};
        end
    end
endmodule
